video_line_dbl: RTL and testbench
=================================

# video_line_dbl

VGA line doubler between the TV-rate pixel pipeline and `video_out`. It captures one TV line of 8-bit plex bytes into one half of a ping-pong line buffer. It then replays the last completed line twice at VGA rate on `vgaplex`, with `vga_line` marking which of the two passes is current. `video_out` consumes `vgaplex` and `vga_line` directly; `vga_line` drives its PWM phase selection in VGA mode.

## Interface
- `LINE_LEN`, 448: maximum plex bytes stored per TV line, per bank.
- `ADDR_W`, 9: pointer width; must satisfy 2^ADDR_W ≥ LINE_LEN + 1.

Ports:
- `clk` in 1: system clock (28 MHz). One clock; every register is clocked on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `tv_line_start` in 1: one-cycle pulse at the start of each TV active line.
- `tv_wr_stb` in 1: one-cycle TV byte strobe (c3-rate); qualifies `vplex_in`.
- `vplex_in` in 8: TV plex byte.
- `vga_line_start` in 1: one-cycle pulse at the start of each VGA active line.
- `vga_rd_stb` in 1: one-cycle VGA byte strobe (2× TV rate).
- `vgaplex` out 8: replayed plex byte.
- `vga_line` out 1: 0 on the first pass of a line, 1 on the repeat.
- `wr_ovf` out 1: sticky; set when a TV line exceeds `LINE_LEN` bytes.
- `sync_err` out 1: one-cycle pulse on a replay underrun or a bank collision.

## Operation
- Storage is 2 × `LINE_LEN` bytes, inferred as a simple dual-port RAM: one write port, one registered read port.
- Per-bank length registers `len[0..1]` (ADDR_W bits) record the bytes written in each completed line.

Write side:
- Registers: `wr_bank`, `wr_ptr`.
- `tv_line_start` does all of the following in one cycle:
  - `len[wr_bank] <= wr_ptr`
  - `done_bank <= wr_bank`
  - `ready <= 1`
  - `wr_bank` toggles
  - `wr_ptr <= 0`
  - `wr_ovf <= 0`
- `tv_wr_stb` with `wr_ptr < LINE_LEN`: writes `vplex_in` to `buf[wr_bank][wr_ptr]`, then `wr_ptr++`.
- `tv_wr_stb` with `wr_ptr == LINE_LEN`: the byte is dropped and `wr_ovf <= 1`.
- `tv_line_start` and `tv_wr_stb` in the same cycle: the start is applied first. The byte goes to address 0 of the new bank and `wr_ptr` becomes 1.

Read side (FSM with states IDLE, PASS0, PASS1):
- **IDLE**: `vgaplex` is held at 0.
  - On `vga_line_start` with `ready`: go to PASS0, `rd_bank <= done_bank`, `ready <= 0`, `vga_line <= 0`.
  - On `vga_line_start` without `ready`: stay in IDLE.
- **PASS0**: on `vga_line_start`, go to PASS1, `vga_line <= 1`; the bank is unchanged.
- **PASS1**: on `vga_line_start`:
  - With `ready`: go to PASS0 with the new `done_bank`, `ready <= 0`, `vga_line <= 0`.
  - Without `ready`: go to PASS0 on the same bank, `vga_line <= 0`, and pulse `sync_err`.
- Every `vga_line_start` sets `rd_ptr <= 0`.
- Reads on `vga_rd_stb` in PASS0/PASS1:
  - With `rd_ptr < len[rd_bank]`: `vgaplex <= buf[rd_bank][rd_ptr]`.
  - Otherwise: `vgaplex <= 0`.
  - `rd_ptr` increments, saturating at `LINE_LEN`.
- `vga_line_start` and `vga_rd_stb` in the same cycle: the start is applied first, so the read uses address 0 and `rd_ptr` becomes 1.
- `tv_line_start` and `vga_line_start` in the same cycle: the FSM sees the `ready` and `done_bank` values being set in that cycle (bypass).
- Bank collision:
  - Trigger: `tv_line_start` while the FSM is in PASS0/PASS1 and the toggled `wr_bank` would equal `rd_bank`.
  - Response: pulse `sync_err`.
  - The write proceeds unchanged; there is no protection. Nominal TV:VGA line ratio is 1:2.
- Reset values:
  - Outputs: `vgaplex` = 0, `vga_line` = 0, `wr_ovf` = 0, `sync_err` = 0.
  - Internal: state IDLE; `wr_bank`, `rd_bank`, `done_bank` = 0; `wr_ptr`, `rd_ptr` = 0; `len[0..1]` = 0; `ready` = 0.
  - RAM contents are not cleared; `len` = 0 guarantees zero output until a line completes.
- Reset mid-line discards the partial line and any pending `ready`.

## Timing
- `vgaplex` is valid the cycle after `vga_rd_stb` and holds until the next read strobe.
- `vga_line` and the FSM state update the cycle after `vga_line_start`.
- A write on `tv_wr_stb` at cycle N is readable from cycle N+1 once its line completes.
- Minimum latency from a TV byte to its VGA output: the next `tv_line_start`, then the next `vga_line_start`, then the matching read strobe.
- `sync_err` is high exactly one cycle, registered, the cycle after the triggering event.
- `wr_ovf` asserts the cycle after the dropped strobe.
- No combinational path from any input to any output.

## Test plan
- **Basic doubling.** Reset; write bytes 0x10..0x1F (16 strobes) and pulse `tv_line_start`; then run 2 VGA lines of 16 read strobes each. Required: `vgaplex` = 0x10..0x1F on both lines, with `vga_line` = 0 on the first and 1 on the second.
- **Short line padding.** Complete a 4-byte line (0xA1..0xA4), then issue 8 read strobes. Required: 0xA1, 0xA2, 0xA3, 0xA4, 0, 0, 0, 0.
- **Overflow.** With `LINE_LEN` = 8, write 10 bytes. Required: `wr_ovf` = 1 after the 9th strobe; replay shows the first 8 bytes only; `wr_ovf` clears on `tv_line_start`.
- **Underrun.** After PASS1, issue `vga_line_start` with no new TV line. Required: one-cycle `sync_err`, `vga_line` = 0, and the same bytes replayed.
- **Simultaneous events.** Assert `tv_line_start` and `tv_wr_stb` together with data 0x55; also assert `tv_line_start` and `vga_line_start` together. Required: 0x55 lands at address 0 of the new bank; the FSM enters PASS0 on the just-completed bank.
- **Reset mid-operation.** Deassert `rst_n` for 1 cycle during PASS1. Required: the next cycle shows `vgaplex` = 0, `vga_line` = 0, FSM in IDLE, and reads return 0 until a full TV line completes.

Source files
------------

// File: rtl/video_line_dbl.sv
// VGA line doubler: captures one TV line of plex bytes into a ping-pong buffer
// and replays the last completed line twice at VGA rate.
module video_line_dbl #(
    parameter int unsigned LINE_LEN = 448,
    parameter int unsigned ADDR_W   = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tv_line_start,
    input  logic       tv_wr_stb,
    input  logic [7:0] vplex_in,
    input  logic       vga_line_start,
    input  logic       vga_rd_stb,
    output logic [7:0] vgaplex,
    output logic       vga_line,
    output logic       wr_ovf,
    output logic       sync_err
);
    localparam int unsigned MEM_DEPTH = 2 * LINE_LEN;
    localparam int unsigned MEM_AW    = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, PASS0, PASS1} state_t;

    state_t            state;
    logic              wr_bank;
    logic              rd_bank;
    logic              done_bank;
    logic              ready;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] len [2];
    logic [7:0]        mem [MEM_DEPTH];

    state_t            state_c;
    logic              rd_bank_c;
    logic              take_c;
    logic              underrun_c;
    logic              collision_c;
    logic              ready_c;
    logic              done_c;
    logic              wr_bank_c;
    logic [ADDR_W-1:0] wr_ptr_c;
    logic              wr_en_c;
    logic [MEM_AW-1:0] wr_addr_c;
    logic [ADDR_W-1:0] rd_ptr_c;
    logic [ADDR_W-1:0] len_c;
    logic              rd_en_c;
    logic              rd_hit_c;
    logic [MEM_AW-1:0] rd_addr_c;

    // Line starts take effect before strobes in the same cycle; the read side
    // sees ready/done_bank/len being set by a coincident TV line start.
    always_comb begin
        wr_ptr_c    = tv_line_start ? '0 : wr_ptr;
        wr_bank_c   = tv_line_start ? ~wr_bank : wr_bank;
        wr_en_c     = tv_wr_stb && (wr_ptr_c < ADDR_W'(LINE_LEN));
        wr_addr_c   = MEM_AW'(wr_ptr_c) + (wr_bank_c ? MEM_AW'(LINE_LEN) : '0);
        ready_c     = ready | tv_line_start;
        done_c      = tv_line_start ? wr_bank : done_bank;
        collision_c = tv_line_start && (state != IDLE) && ((~wr_bank) == rd_bank);

        state_c    = state;
        rd_bank_c  = rd_bank;
        take_c     = 1'b0;
        underrun_c = 1'b0;
        if (vga_line_start) begin
            case (state)
                IDLE: begin
                    if (ready_c) begin
                        state_c   = PASS0;
                        rd_bank_c = done_c;
                        take_c    = 1'b1;
                    end
                end
                PASS0: state_c = PASS1;
                PASS1: begin
                    state_c = PASS0;
                    if (ready_c) begin
                        rd_bank_c = done_c;
                        take_c    = 1'b1;
                    end else begin
                        underrun_c = 1'b1;
                    end
                end
                default: state_c = IDLE;
            endcase
        end

        rd_ptr_c  = vga_line_start ? '0 : rd_ptr;
        len_c     = (tv_line_start && (rd_bank_c == wr_bank)) ? wr_ptr : len[rd_bank_c];
        rd_en_c   = vga_rd_stb && (state_c != IDLE);
        rd_hit_c  = rd_ptr_c < len_c;
        rd_addr_c = MEM_AW'(rd_ptr_c) + (rd_bank_c ? MEM_AW'(LINE_LEN) : '0);
    end

    // Line storage write port; contents are never cleared.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_addr_c] <= vplex_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            done_bank <= 1'b0;
            ready     <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            len[0]    <= '0;
            len[1]    <= '0;
            vgaplex   <= 8'h00;
            vga_line  <= 1'b0;
            wr_ovf    <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            if (tv_line_start) begin
                len[wr_bank] <= wr_ptr;
                done_bank    <= wr_bank;
                wr_ovf       <= 1'b0;
            end
            if (tv_wr_stb && !wr_en_c) begin
                wr_ovf <= 1'b1;
            end
            wr_bank  <= wr_bank_c;
            wr_ptr   <= wr_en_c ? (wr_ptr_c + ADDR_W'(1)) : wr_ptr_c;
            ready    <= ready_c & ~take_c;
            state    <= state_c;
            rd_bank  <= rd_bank_c;
            sync_err <= underrun_c | collision_c;
            if (vga_line_start) begin
                vga_line <= (state_c == PASS1);
            end
            // Read pointer saturates at LINE_LEN; reads past the line length return 0.
            if (rd_en_c) begin
                vgaplex <= rd_hit_c ? mem[rd_addr_c] : 8'h00;
                rd_ptr  <= (rd_ptr_c == ADDR_W'(LINE_LEN)) ? rd_ptr_c : (rd_ptr_c + ADDR_W'(1));
            end else begin
                rd_ptr <= rd_ptr_c;
            end
        end
    end

endmodule

// File: tb/tb_video_line_dbl.sv
// Directed bench for video_line_dbl: a full-size instance and an 8-byte-line
// instance share stimulus; each check targets the instance under test.
module tb_video_line_dbl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tv_line_start = 1'b0;
    logic       tv_wr_stb = 1'b0;
    logic [7:0] vplex_in = 8'h00;
    logic       vga_line_start = 1'b0;
    logic       vga_rd_stb = 1'b0;

    logic [7:0] vgaplex_a, vgaplex_b;
    logic       vga_line_a, vga_line_b;
    logic       wr_ovf_a, wr_ovf_b;
    logic       sync_err_a, sync_err_b;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    video_line_dbl #(.LINE_LEN(448), .ADDR_W(9)) dut_a (
        .clk(clk), .rst_n(rst_n), .tv_line_start(tv_line_start), .tv_wr_stb(tv_wr_stb),
        .vplex_in(vplex_in), .vga_line_start(vga_line_start), .vga_rd_stb(vga_rd_stb),
        .vgaplex(vgaplex_a), .vga_line(vga_line_a), .wr_ovf(wr_ovf_a), .sync_err(sync_err_a)
    );

    video_line_dbl #(.LINE_LEN(8), .ADDR_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .tv_line_start(tv_line_start), .tv_wr_stb(tv_wr_stb),
        .vplex_in(vplex_in), .vga_line_start(vga_line_start), .vga_rd_stb(vga_rd_stb),
        .vgaplex(vgaplex_b), .vga_line(vga_line_b), .wr_ovf(wr_ovf_b), .sync_err(sync_err_b)
    );

    typedef struct {
        logic       sel;    // 0: LINE_LEN=448 instance, 1: LINE_LEN=8 instance
        logic [7:0] base;
        int         nwr;
        int         nrd;
        int         nkeep;  // bytes the line buffer retains
        logic       ovf;
    } line_vec_t;

    line_vec_t vecs [3];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic tv_byte(input logic [7:0] d);
        tv_wr_stb = 1'b1;
        vplex_in  = d;
        tick();
        tv_wr_stb = 1'b0;
    endtask

    task automatic tv_start();
        tv_line_start = 1'b1;
        tick();
        tv_line_start = 1'b0;
    endtask

    task automatic vga_start();
        vga_line_start = 1'b1;
        tick();
        vga_line_start = 1'b0;
    endtask

    task automatic rd_a(input string name, input logic [7:0] exp);
        vga_rd_stb = 1'b1;
        tick();
        vga_rd_stb = 1'b0;
        chk(name, vgaplex_a, exp);
    endtask

    initial begin
        vecs[0] = '{sel: 1'b0, base: 8'h10, nwr: 16, nrd: 16, nkeep: 16, ovf: 1'b0};
        vecs[1] = '{sel: 1'b0, base: 8'hA1, nwr: 4,  nrd: 8,  nkeep: 4,  ovf: 1'b0};
        vecs[2] = '{sel: 1'b1, base: 8'h30, nwr: 10, nrd: 10, nkeep: 8,  ovf: 1'b1};

        tick();
        do_reset();
        chk("reset_vgaplex", vgaplex_a, 8'h00);
        chk("reset_vga_line", {7'd0, vga_line_a}, 8'h00);
        chk("reset_wr_ovf", {7'd0, wr_ovf_a}, 8'h00);
        chk("reset_sync_err", {7'd0, sync_err_a}, 8'h00);

        // Table-driven line capture and double replay
        for (int v = 0; v < 3; v++) begin
            do_reset();
            for (int i = 0; i < vecs[v].nwr; i++) begin
                tv_byte(vecs[v].base + 8'(i));
                chk($sformatf("v%0d_ovf_w%0d", v, i),
                    {7'd0, vecs[v].sel ? wr_ovf_b : wr_ovf_a}, {7'd0, i >= vecs[v].nkeep});
            end
            chk($sformatf("v%0d_ovf_end", v), {7'd0, vecs[v].sel ? wr_ovf_b : wr_ovf_a},
                {7'd0, vecs[v].ovf});
            tv_start();
            chk($sformatf("v%0d_ovf_clr", v), {7'd0, vecs[v].sel ? wr_ovf_b : wr_ovf_a}, 8'h00);
            for (int p = 0; p < 2; p++) begin
                vga_start();
                chk($sformatf("v%0d_line%0d", v, p),
                    {7'd0, vecs[v].sel ? vga_line_b : vga_line_a}, 8'(p));
                for (int i = 0; i < vecs[v].nrd; i++) begin
                    vga_rd_stb = 1'b1;
                    tick();
                    vga_rd_stb = 1'b0;
                    chk($sformatf("v%0d_p%0d_rd%0d", v, p, i),
                        vecs[v].sel ? vgaplex_b : vgaplex_a,
                        (i < vecs[v].nkeep) ? (vecs[v].base + 8'(i)) : 8'h00);
                end
            end
        end

        // Underrun after PASS1, then a bank collision
        do_reset();
        tv_byte(8'h61); tv_byte(8'h62); tv_byte(8'h63);
        tv_start();
        vga_start();
        vga_start();
        chk("ur_line1", {7'd0, vga_line_a}, 8'h01);
        chk("ur_no_err", {7'd0, sync_err_a}, 8'h00);
        vga_start();
        chk("ur_err", {7'd0, sync_err_a}, 8'h01);
        chk("ur_line0", {7'd0, vga_line_a}, 8'h00);
        tick();
        chk("ur_err_pulse", {7'd0, sync_err_a}, 8'h00);
        rd_a("ur_rd0", 8'h61);
        rd_a("ur_rd1", 8'h62);
        rd_a("ur_rd2", 8'h63);
        tv_start();
        chk("coll_err", {7'd0, sync_err_a}, 8'h01);
        tick();
        chk("coll_err_pulse", {7'd0, sync_err_a}, 8'h00);

        // Coincident TV start + write + VGA start
        do_reset();
        tv_byte(8'h71); tv_byte(8'h72);
        tv_line_start = 1'b1; tv_wr_stb = 1'b1; vplex_in = 8'h55; vga_line_start = 1'b1;
        tick();
        tv_line_start = 1'b0; tv_wr_stb = 1'b0; vga_line_start = 1'b0;
        chk("sim_line0", {7'd0, vga_line_a}, 8'h00);
        chk("sim_no_err", {7'd0, sync_err_a}, 8'h00);
        rd_a("sim_rd0", 8'h71);
        rd_a("sim_rd1", 8'h72);
        rd_a("sim_rd2", 8'h00);
        tv_start();
        chk("sim_coll", {7'd0, sync_err_a}, 8'h01);
        vga_start();
        chk("sim_pass1", {7'd0, vga_line_a}, 8'h01);
        vga_line_start = 1'b1; vga_rd_stb = 1'b1;
        tick();
        vga_line_start = 1'b0; vga_rd_stb = 1'b0;
        chk("sim_55_addr0", vgaplex_a, 8'h55);
        chk("sim_newline0", {7'd0, vga_line_a}, 8'h00);
        chk("sim_newbank_ok", {7'd0, sync_err_a}, 8'h00);
        rd_a("sim_len1", 8'h00);

        // Reset during PASS1
        do_reset();
        tv_byte(8'h81); tv_byte(8'h82);
        tv_start();
        vga_start();
        vga_start();
        rd_a("rst_pre_rd", 8'h81);
        do_reset();
        chk("rst_vgaplex", vgaplex_a, 8'h00);
        chk("rst_vga_line", {7'd0, vga_line_a}, 8'h00);
        vga_start();
        rd_a("rst_idle_rd", 8'h00);
        tv_byte(8'h91);
        vga_start();
        rd_a("rst_partial_rd", 8'h00);
        chk("rst_idle_line", {7'd0, vga_line_a}, 8'h00);
        tv_start();
        vga_start();
        rd_a("rst_new_rd", 8'h91);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
